// File: rtl/ecc_scrub8.sv
`default_nettype none
// ============================================================================
// Module   : ecc_scrub8
// Brief    : Hamming(12,8) SEC RAM controller with a user port and a background
//            scrubber. Define ECC_RDWB_EN to also repair words on user reads.
// Revision : 1.0 - initial release
// ============================================================================
module ecc_scrub8 #(
    parameter int ADDR_W       = 8,
    parameter int SCRUB_PERIOD = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scrub_en,
    input  logic              usr_req,
    input  logic              usr_wr,
    input  logic [ADDR_W-1:0] usr_addr,
    input  logic [7:0]        usr_wdat,
    output logic              usr_ack,
    output logic              usr_rvld,
    output logic [7:0]        usr_rdat,
    output logic              usr_cerr,
    output logic              usr_uerr,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [11:0]       mem_wdat,
    input  logic [11:0]       mem_rdat,
    output logic              scrub_done,
    output logic [15:0]       err_cnt
);

    localparam int                c_TMR_W    = $clog2(SCRUB_PERIOD);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(SCRUB_PERIOD - 1);
    localparam logic [ADDR_W-1:0]  c_ADDR_MAX = {ADDR_W{1'b1}};

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_UWR  = 3'd1;
    localparam logic [2:0] c_URD  = 3'd2;
    localparam logic [2:0] c_UCHK = 3'd3;
    localparam logic [2:0] c_SRD  = 3'd4;
    localparam logic [2:0] c_SCHK = 3'd5;
    localparam logic [2:0] c_SWB  = 3'd6;
`ifdef ECC_RDWB_EN
    localparam logic [2:0] c_UWB  = 3'd7;
`endif

    logic [2:0]         r_state;
    logic [ADDR_W-1:0]  r_saddr;
    logic [c_TMR_W-1:0] r_timer;
    logic               r_pend;
    logic               r_usr_last;

    logic [11:0] w_enc;
    logic [3:0]  w_syn;
    logic        w_cerr;
    logic        w_uerr;
    logic [11:0] w_fixed;
    logic [7:0]  w_rdat;
    logic        w_scrub_end;

    // Codeword bit i is Hamming position i+1; parity bits sit at positions 1,2,4,8.
    function automatic logic [11:0] f_encode(input logic [7:0] d);
        logic p1, p2, p4, p8;
        p1 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        p2 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        p4 = d[1] ^ d[2] ^ d[3] ^ d[7];
        p8 = d[4] ^ d[5] ^ d[6] ^ d[7];
        return {d[7], d[6], d[5], d[4], p8, d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    assign w_enc    = f_encode(usr_wdat);
    assign w_syn[0] = ^{mem_rdat[0], mem_rdat[2], mem_rdat[4], mem_rdat[6], mem_rdat[8], mem_rdat[10]};
    assign w_syn[1] = ^{mem_rdat[1], mem_rdat[2], mem_rdat[5], mem_rdat[6], mem_rdat[9], mem_rdat[10]};
    assign w_syn[2] = ^{mem_rdat[3], mem_rdat[4], mem_rdat[5], mem_rdat[6], mem_rdat[11]};
    assign w_syn[3] = ^{mem_rdat[7], mem_rdat[8], mem_rdat[9], mem_rdat[10], mem_rdat[11]};
    assign w_cerr   = (w_syn != 4'd0) && (w_syn <= 4'd12);
    assign w_uerr   = (w_syn >= 4'd13);
    assign w_fixed  = w_cerr ? (mem_rdat ^ (12'd1 << (w_syn - 4'd1))) : mem_rdat;
    assign w_rdat   = {w_fixed[11:8], w_fixed[6:4], w_fixed[2]};

    assign w_scrub_end = ((r_state == c_SCHK) && !w_cerr) || (r_state == c_SWB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_saddr    <= '0;
            r_timer    <= '0;
            r_pend     <= 1'b0;
            r_usr_last <= 1'b0;
            usr_ack    <= 1'b0;
            usr_rvld   <= 1'b0;
            usr_rdat   <= '0;
            usr_cerr   <= 1'b0;
            usr_uerr   <= 1'b0;
            mem_ce     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdat   <= '0;
            scrub_done <= 1'b0;
            err_cnt    <= '0;
        end else begin
            mem_ce     <= 1'b0;
            mem_we     <= 1'b0;
            usr_ack    <= 1'b0;
            usr_rvld   <= 1'b0;
            scrub_done <= 1'b0;

            // A timer expiry on the same edge a scrub finishes keeps the new request.
            if (!scrub_en) begin
                r_timer <= '0;
                r_pend  <= 1'b0;
            end else if (r_timer == c_TMR_LAST) begin
                r_timer <= '0;
                r_pend  <= 1'b1;
            end else begin
                r_timer <= r_timer + c_TMR_W'(1);
                if (w_scrub_end) r_pend <= 1'b0;
            end

            case (r_state)
                c_IDLE: begin
                    r_usr_last <= 1'b0;
                    // Right after a user access a pending scrub takes the next slot.
                    if (usr_req && !(r_pend && r_usr_last)) begin
                        r_usr_last <= 1'b1;
                        mem_ce     <= 1'b1;
                        mem_addr   <= usr_addr;
                        usr_ack    <= 1'b1;
                        if (usr_wr) begin
                            mem_we   <= 1'b1;
                            mem_wdat <= w_enc;
                            r_state  <= c_UWR;
                        end else begin
                            r_state  <= c_URD;
                        end
                    end else if (r_pend) begin
                        mem_ce   <= 1'b1;
                        mem_addr <= r_saddr;
                        r_state  <= c_SRD;
                    end
                end
                c_UWR: r_state <= c_IDLE;
                c_URD: r_state <= c_UCHK;
                c_UCHK: begin
                    usr_rvld <= 1'b1;
                    usr_rdat <= w_rdat;
                    usr_cerr <= w_cerr;
                    usr_uerr <= w_uerr;
                    if (w_cerr && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
`ifdef ECC_RDWB_EN
                    if (w_cerr) begin
                        mem_ce   <= 1'b1;
                        mem_we   <= 1'b1;
                        mem_wdat <= w_fixed;
                        r_state  <= c_UWB;
                    end else begin
                        r_state  <= c_IDLE;
                    end
`else
                    r_state <= c_IDLE;
`endif
                end
`ifdef ECC_RDWB_EN
                c_UWB: r_state <= c_IDLE;
`endif
                c_SRD: r_state <= c_SCHK;
                c_SCHK: begin
                    if (w_cerr) begin
                        mem_ce   <= 1'b1;
                        mem_we   <= 1'b1;
                        mem_wdat <= w_fixed;
                        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                        r_state  <= c_SWB;
                    end else begin
                        r_saddr    <= r_saddr + ADDR_W'(1);
                        scrub_done <= (r_saddr == c_ADDR_MAX);
                        r_state    <= c_IDLE;
                    end
                end
                c_SWB: begin
                    r_saddr    <= r_saddr + ADDR_W'(1);
                    scrub_done <= (r_saddr == c_ADDR_MAX);
                    r_state    <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ecc_scrub8.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecc_scrub8
// Brief    : Self-checking bench for ecc_scrub8 with a behavioural RAM and
//            Hamming model (honours ECC_RDWB_EN when defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ecc_scrub8;

    localparam int ADDR_W       = 4;
    localparam int SCRUB_PERIOD = 16;
    localparam int DEPTH        = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              scrub_en;
    logic              usr_req;
    logic              usr_wr;
    logic [ADDR_W-1:0] usr_addr;
    logic [7:0]        usr_wdat;
    logic              usr_ack;
    logic              usr_rvld;
    logic [7:0]        usr_rdat;
    logic              usr_cerr;
    logic              usr_uerr;
    logic              mem_ce;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [11:0]       mem_wdat;
    logic [11:0]       mem_rdat = 12'd0;
    logic              scrub_done;
    logic [15:0]       err_cnt;

    always #5 clk = ~clk;

    ecc_scrub8 #(.ADDR_W(ADDR_W), .SCRUB_PERIOD(SCRUB_PERIOD)) dut (
        .clk(clk), .rst(rst), .scrub_en(scrub_en),
        .usr_req(usr_req), .usr_wr(usr_wr), .usr_addr(usr_addr), .usr_wdat(usr_wdat),
        .usr_ack(usr_ack), .usr_rvld(usr_rvld), .usr_rdat(usr_rdat),
        .usr_cerr(usr_cerr), .usr_uerr(usr_uerr),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdat(mem_wdat), .mem_rdat(mem_rdat),
        .scrub_done(scrub_done), .err_cnt(err_cnt)
    );

    logic [11:0] ram    [DEPTH];
    logic [7:0]  golden [DEPTH];
    int n_tot = 0;
    int n_bad = 0;
    int cyc = 0;
    int exp_err = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int rd_at_done = 0;
    bit mon_on = 1'b0;
    int mon_addr_q[$];
    int mon_cyc_q[$];

    // Syndrome as the XOR of the positions of all set bits; zero for a clean word.
    function automatic logic [3:0] f_syn(input logic [11:0] cw);
        logic [3:0] s;
        s = 4'd0;
        for (int p = 1; p <= 12; p++) if (cw[p-1]) s = s ^ p[3:0];
        return s;
    endfunction

    function automatic logic [11:0] f_enc(input logic [7:0] d);
        int dpos[8];
        logic [11:0] cw;
        logic [3:0] s;
        dpos = '{3, 5, 6, 7, 9, 10, 11, 12};
        cw = 12'd0;
        for (int i = 0; i < 8; i++) cw[dpos[i]-1] = d[i];
        s = f_syn(cw);
        cw[0] = s[0]; cw[1] = s[1]; cw[3] = s[2]; cw[7] = s[3];
        return cw;
    endfunction

    function automatic logic [7:0] f_ext(input logic [11:0] cw);
        int dpos[8];
        logic [7:0] d;
        dpos = '{3, 5, 6, 7, 9, 10, 11, 12};
        for (int i = 0; i < 8; i++) d[i] = cw[dpos[i]-1];
        return d;
    endfunction

    function automatic bit f_corr(input logic [11:0] cw);
        logic [3:0] s;
        s = f_syn(cw);
        return (s >= 4'd1) && (s <= 4'd12);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: one-cycle read latency, also tallies correctable words read.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_err <= 0;
        end else begin
            if (mem_ce && mem_we) begin
                ram[mem_addr] = mem_wdat;
                wr_cnt <= wr_cnt + 1;
            end else if (mem_ce) begin
                mem_rdat <= ram[mem_addr];
                if (f_corr(ram[mem_addr])) exp_err <= exp_err + 1;
                if (mon_on) begin
                    mon_addr_q.push_back(int'(mem_addr));
                    mon_cyc_q.push_back(cyc);
                end
            end
            if (scrub_done) begin
                done_cnt   <= done_cnt + 1;
                rd_at_done <= mon_addr_q.size();
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_ack(output int lat);
        bit seen;
        seen = 1'b0;
        lat = 0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            seen = usr_ack;
        end
        if (!seen) check("ack_timeout", 32'(seen), 32'd1);
    endtask

    task automatic pulse_rst();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic usr_write(input logic [ADDR_W-1:0] a, input logic [7:0] d, input bit chk_lat);
        int lat;
        @(negedge clk);
        usr_req = 1'b1; usr_wr = 1'b1; usr_addr = a; usr_wdat = d;
        wait_ack(lat);
        usr_req = 1'b0;
        check("wr_strobe", 32'({mem_ce, mem_we}), 32'd3);
        check("wr_addr", 32'(mem_addr), 32'(a));
        check("wr_code", 32'(mem_wdat), 32'(f_enc(d)));
        if (chk_lat) check("wr_lat", 32'(lat), 32'd1);
        golden[a] = d;
    endtask

    task automatic usr_read(input logic [ADDR_W-1:0] a, input bit sync_srd,
                            input int lat_lo, input int lat_hi);
        int lat;
        int n;
        logic [11:0] raw;
        logic [11:0] exp_ram;
        logic [3:0] s;
        @(negedge clk);
        if (sync_srd) begin
            n = 0;
            while (!(mem_ce && !mem_we) && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("srd_seen", 32'(n < 200), 32'd1);
        end
        usr_req = 1'b1; usr_wr = 1'b0; usr_addr = a;
        wait_ack(lat);
        usr_req = 1'b0;
        raw = ram[a];
        s = f_syn(raw);
        check("rd_lat", 32'(lat >= lat_lo && lat <= lat_hi), 32'd1);
        check("rd_addr", 32'(mem_addr), 32'(a));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!usr_rvld && n < 10);
        check("rvld_lat", 32'(n), 32'd2);
        check("rd_data", 32'(usr_rdat), (s >= 4'd13) ? 32'(f_ext(raw)) : 32'(golden[a]));
        check("rd_cerr", 32'(usr_cerr), 32'(f_corr(raw)));
        check("rd_uerr", 32'(usr_uerr), 32'(s >= 4'd13));
        @(negedge clk);
`ifdef ECC_RDWB_EN
        exp_ram = f_corr(raw) ? f_enc(golden[a]) : raw;
`else
        exp_ram = raw;
`endif
        check("rd_wback", 32'(ram[a]), 32'(exp_ram));
    endtask

    initial begin
        int n;
        int base;
        int w0;
        logic [ADDR_W-1:0] a;
        rst = 1'b1; scrub_en = 1'b0; usr_req = 1'b0; usr_wr = 1'b0;
        usr_addr = '0; usr_wdat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            golden[i] = 8'($urandom);
            ram[i] = f_enc(golden[i]);
        end
        repeat (3) @(negedge clk);
        check("rst_ctl", 32'({usr_ack, usr_rvld, usr_cerr, usr_uerr, mem_ce, mem_we, scrub_done}), 32'd0);
        check("rst_cnt", 32'(err_cnt), 32'd0);
        check("rst_bus", 32'({mem_addr, mem_wdat, usr_rdat}), 32'd0);
        rst = 1'b0;

        // basic write / read round trip
        usr_write(4'h5, 8'hA5, 1'b1);
        usr_read(4'h5, 1'b0, 1, 1);

        // single-bit error at position 5
        ram[5] = ram[5] ^ 12'h010;
        usr_read(4'h5, 1'b0, 1, 1);
        check("cerr_cnt", 32'(err_cnt), 32'd1);
        usr_write(4'h5, 8'hA5, 1'b1);

        // double error giving syndrome 14 is reported, not corrected
        ram[6] = f_enc(golden[6]) ^ 12'h802;
        base = int'(err_cnt);
        usr_read(4'h6, 1'b0, 1, 1);
        check("uerr_cnt", 32'(err_cnt), 32'(base));
        usr_write(4'h6, golden[6], 1'b1);

        // full scrub pass repairing one word
        pulse_rst();
        mon_addr_q.delete();
        mon_cyc_q.delete();
        base = done_cnt;
        mon_on = 1'b1;
        ram[2] = ram[2] ^ 12'h040;
        scrub_en = 1'b1;
        n = 0;
        while (done_cnt == base && n < DEPTH * SCRUB_PERIOD + 100) begin
            @(negedge clk);
            n++;
        end
        mon_on = 1'b0;
        check("done_seen", 32'(done_cnt - base), 32'd1);
        check("done_after", 32'(rd_at_done), 32'(DEPTH));
        for (int i = 0; i < DEPTH && i < mon_addr_q.size(); i++)
            check("scrub_addr", 32'(mon_addr_q[i]), 32'(i));
        if (mon_cyc_q.size() >= 2)
            check("scrub_gap", 32'(mon_cyc_q[1] - mon_cyc_q[0]), 32'(SCRUB_PERIOD));
        else
            check("scrub_gap_cnt", 32'(mon_cyc_q.size()), 32'd2);
        check("scrub_fix", 32'(ram[2]), 32'(f_enc(golden[2])));
        check("scrub_cnt", 32'(err_cnt), 32'd1);

        // user request arriving as a scrub starts waits for it
        ram[4'($urandom_range(0, DEPTH-1))] ^= 12'h001;
        usr_read(ADDR_W'($urandom_range(0, DEPTH-1)), 1'b1, 3, 4);

        // reset while a correction is pending in SCHK
        scrub_en = 1'b0;
        pulse_rst();
        for (int i = 0; i < DEPTH; i++) ram[i] = f_enc(golden[i]);
        ram[0] = ram[0] ^ 12'h100;
        w0 = wr_cnt;
        scrub_en = 1'b1;
        n = 0;
        while (!(mem_ce && !mem_we && mem_addr == '0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("srd0_seen", 32'(n < 100), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        scrub_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_no_wr", 32'(wr_cnt - w0), 32'd0);
        check("rst_errcnt", 32'(err_cnt), 32'd0);
        check("rst_ram", 32'(ram[0]), 32'(f_enc(golden[0]) ^ 12'h100));
        usr_read('0, 1'b0, 1, 1);

        // randomized traffic with scrubbing and fault injection
        scrub_en = 1'b1;
        for (int k = 0; k < 250; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            a = ADDR_W'($urandom_range(0, DEPTH-1));
            if (r < 3) usr_write(a, 8'($urandom), 1'b0);
            else if (r < 7) usr_read(a, 1'b0, 1, 6);
            else if (r < 9) begin
                @(negedge clk);
                if (f_syn(ram[a]) == 4'd0) ram[a] = ram[a] ^ (12'd1 << $urandom_range(0, 11));
            end else repeat ($urandom_range(1, 20)) @(negedge clk);
        end
        repeat (DEPTH * SCRUB_PERIOD + 64) @(negedge clk);
        for (int i = 0; i < DEPTH; i++)
            check("sweep_word", 32'(ram[i]), 32'(f_enc(golden[i])));
        check("final_cnt", 32'(err_cnt), 32'(exp_err));

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
